// File: rtl/controle_preempcao.sv
// Preemption and round-robin context controller: raises the scheduler / I/O redirect
// requests for the PC-select logic and keeps each process's resume PC for dispatch.
module controle_preempcao #(
   parameter  int unsigned QUANTUM  = 16,
   parameter  int unsigned NUM_PROC = 4,
   localparam int unsigned IW       = $clog2(NUM_PROC)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                habilita,
   input  logic                carrega_processo,
   input  logic [IW-1:0]       slot_carga,
   input  logic [31:0]         pc_carga,
   input  logic [31:0]         pc,
   input  logic                instrucao_io,
   input  logic                fim_processo,
   input  logic                despacho,
   output logic                troca_contexto,
   output logic                intrucao_io_contexto,
   output logic [31:0]         pc_processo_trocado,
   output logic [IW-1:0]       processo_atual,
   output logic [NUM_PROC-1:0] processos_ativos,
   output logic [7:0]          contador
);

   typedef enum logic [1:0] {OCIOSO, EXECUTANDO, AGUARDA_IO, ESCALONANDO} estado_t;

   localparam logic [7:0] CONT_MAX = 8'(QUANTUM - 1);

   estado_t             estado_q, estado_d;
   logic [31:0]         tabela_q [NUM_PROC];
   logic [31:0]         tabela_d [NUM_PROC];
   logic [NUM_PROC-1:0] valido_q, valido_d;
   logic [IW-1:0]       atual_q, atual_d;
   logic [31:0]         pc_troca_q, pc_troca_d;
   logic [7:0]          contador_q, contador_d;
   logic                troca_q, troca_d;
   logic                io_q, io_d;
   logic                primeiro_q, primeiro_d;

   logic                achou;
   logic [IW-1:0]       escolhido;
   logic [IW-1:0]       candidato;

   // Until a process has run, the search starts at slot 0 instead of atual+1.
   always_comb begin
      achou     = 1'b0;
      escolhido = atual_q;
      candidato = '0;
      for (int unsigned i = 0; i < NUM_PROC; i++) begin
         candidato = primeiro_q ? IW'(i) : IW'(32'(atual_q) + i + 32'd1);
         if (!achou && valido_q[candidato]) begin
            achou     = 1'b1;
            escolhido = candidato;
         end
      end
   end

   always_comb begin
      estado_d   = estado_q;
      tabela_d   = tabela_q;
      valido_d   = valido_q;
      atual_d    = atual_q;
      pc_troca_d = pc_troca_q;
      contador_d = contador_q;
      troca_d    = 1'b0;
      io_d       = 1'b0;
      primeiro_d = primeiro_q;

      if (!habilita) begin
         estado_d   = OCIOSO;
         contador_d = '0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               contador_d = '0;
               if (|valido_q) estado_d = ESCALONANDO;
            end
            // Event edges hold the count so it never passes QUANTUM-1.
            EXECUTANDO: begin
               if (fim_processo) begin
                  valido_d[atual_q] = 1'b0;
                  troca_d           = 1'b1;
                  estado_d          = ESCALONANDO;
               end else if (instrucao_io) begin
                  tabela_d[atual_q] = pc + 32'd1;
                  io_d              = 1'b1;
                  estado_d          = AGUARDA_IO;
               end else if (contador_q >= CONT_MAX) begin
                  tabela_d[atual_q] = pc;
                  troca_d           = 1'b1;
                  contador_d        = '0;
                  estado_d          = ESCALONANDO;
               end else begin
                  contador_d = contador_q + 8'd1;
               end
            end
            AGUARDA_IO, ESCALONANDO: begin
               if (despacho) begin
                  contador_d = '0;
                  if (achou) begin
                     atual_d    = escolhido;
                     pc_troca_d = tabela_q[escolhido];
                     primeiro_d = 1'b0;
                     estado_d   = EXECUTANDO;
                  end else begin
                     estado_d = OCIOSO;
                  end
               end
            end
            default: estado_d = OCIOSO;
         endcase
      end

      if (carrega_processo) begin
         tabela_d[slot_carga] = pc_carga;
         valido_d[slot_carga] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q   <= OCIOSO;
         tabela_q   <= '{default: '0};
         valido_q   <= '0;
         atual_q    <= '0;
         pc_troca_q <= '0;
         contador_q <= '0;
         troca_q    <= 1'b0;
         io_q       <= 1'b0;
         primeiro_q <= 1'b1;
      end else begin
         estado_q   <= estado_d;
         tabela_q   <= tabela_d;
         valido_q   <= valido_d;
         atual_q    <= atual_d;
         pc_troca_q <= pc_troca_d;
         contador_q <= contador_d;
         troca_q    <= troca_d;
         io_q       <= io_d;
         primeiro_q <= primeiro_d;
      end
   end

   assign troca_contexto       = troca_q;
   assign intrucao_io_contexto = io_q;
   assign pc_processo_trocado  = pc_troca_q;
   assign processo_atual       = atual_q;
   assign processos_ativos     = valido_q;
   assign contador             = contador_q;

endmodule

// File: tb/tb_controle_preempcao.sv
// Bench for controle_preempcao: directed vector table, hand sequences for reset and
// habilita corner cases, then random stimulus against a behavioural model.
module tb_controle_preempcao;

   localparam int Q  = 4;
   localparam int NP = 4;

   logic        clock, reset, habilita, carrega_processo;
   logic [1:0]  slot_carga;
   logic [31:0] pc_carga, pc;
   logic        instrucao_io, fim_processo, despacho;
   logic        troca_contexto, intrucao_io_contexto;
   logic [31:0] pc_processo_trocado;
   logic [1:0]  processo_atual;
   logic [3:0]  processos_ativos;
   logic [7:0]  contador;

   controle_preempcao #(.QUANTUM(Q), .NUM_PROC(NP)) dut (
      .clock(clock), .reset(reset), .habilita(habilita),
      .carrega_processo(carrega_processo), .slot_carga(slot_carga), .pc_carga(pc_carga),
      .pc(pc), .instrucao_io(instrucao_io), .fim_processo(fim_processo), .despacho(despacho),
      .troca_contexto(troca_contexto), .intrucao_io_contexto(intrucao_io_contexto),
      .pc_processo_trocado(pc_processo_trocado), .processo_atual(processo_atual),
      .processos_ativos(processos_ativos), .contador(contador)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int passou = 0;

   task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      total++;
      if (atual === esperado) passou++;
      else $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic limpa();
      carrega_processo = 1'b0; slot_carga = '0; pc_carga = '0; pc = '0;
      instrucao_io = 1'b0; fim_processo = 1'b0; despacho = 1'b0;
   endtask

   task automatic chk_all(input string p, input int tc, input int ioc, input int pct,
                          input int pa, input int act, input int cnt);
      chk({p, ".troca"}, 32'(troca_contexto), 32'(tc));
      chk({p, ".io_ctx"}, 32'(intrucao_io_contexto), 32'(ioc));
      chk({p, ".pc_troc"}, pc_processo_trocado, 32'(pct));
      chk({p, ".atual"}, 32'(processo_atual), 32'(pa));
      chk({p, ".ativos"}, 32'(processos_ativos), 32'(act));
      chk({p, ".cont"}, 32'(contador), 32'(cnt));
   endtask

   typedef struct {
      int hab, ld, slot, pcl, pcv, io, fim, dsp;
      int tc, ioc, pct, pa, act, cnt;
   } vec_t;
   vec_t vt[$];

   function automatic vec_t mk(int hab, int ld, int slot, int pcl, int pcv, int io, int fim,
                               int dsp, int tc, int ioc, int pct, int pa, int act, int cnt);
      vec_t v;
      v.hab = hab; v.ld = ld; v.slot = slot; v.pcl = pcl; v.pcv = pcv;
      v.io = io; v.fim = fim; v.dsp = dsp;
      v.tc = tc; v.ioc = ioc; v.pct = pct; v.pa = pa; v.act = act; v.cnt = cnt;
      return v;
   endfunction

   // Behavioural reference: named modes, arrays, modulo search from the last runner.
   typedef enum {M_IDLE, M_RUN, M_IO, M_SCHED} modo_t;
   modo_t       m_modo;
   int          m_ultimo;
   logic [31:0] m_tab [NP];
   bit          m_val [NP];
   int          m_cnt;
   bit          m_tc, m_ioc;
   logic [31:0] m_pct;

   task automatic model_reset();
      m_modo = M_IDLE; m_ultimo = -1; m_cnt = 0; m_tc = 0; m_ioc = 0; m_pct = '0;
      for (int k = 0; k < NP; k++) begin m_tab[k] = '0; m_val[k] = 0; end
   endtask

   function automatic int m_pa();
      return (m_ultimo < 0) ? 0 : m_ultimo;
   endfunction

   function automatic int m_act();
      int a = 0;
      for (int k = 0; k < NP; k++) if (m_val[k]) a += (1 << k);
      return a;
   endfunction

   task automatic model_edge();
      int  base, achado;
      bit  algum;
      m_tc = 0; m_ioc = 0;
      algum = 0;
      for (int k = 0; k < NP; k++) if (m_val[k]) algum = 1;
      if (!habilita) begin
         m_modo = M_IDLE; m_cnt = 0;
      end else if (m_modo == M_IDLE) begin
         m_cnt = 0;
         if (algum) m_modo = M_SCHED;
      end else if (m_modo == M_RUN) begin
         if (fim_processo) begin
            m_val[m_pa()] = 0; m_tc = 1; m_modo = M_SCHED;
         end else if (instrucao_io) begin
            m_tab[m_pa()] = pc + 32'd1; m_ioc = 1; m_modo = M_IO;
         end else if (m_cnt == Q - 1) begin
            m_tab[m_pa()] = pc; m_tc = 1; m_cnt = 0; m_modo = M_SCHED;
         end else begin
            m_cnt++;
         end
      end else if (despacho) begin
         base = (m_ultimo < 0) ? NP - 1 : m_ultimo;
         achado = -1;
         for (int j = 1; j <= NP; j++)
            if (achado < 0 && m_val[(base + j) % NP]) achado = (base + j) % NP;
         m_cnt = 0;
         if (achado >= 0) begin
            m_ultimo = achado; m_pct = m_tab[achado]; m_modo = M_RUN;
         end else begin
            m_modo = M_IDLE;
         end
      end
      if (carrega_processo) begin
         m_tab[slot_carga] = pc_carga; m_val[slot_carga] = 1;
      end
   endtask

   initial begin
      reset = 1'b0; habilita = 1'b0; limpa();
      #12;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      reset = 1'b1;

      //          hab ld sl pcl pc io fim dsp | tc ioc pct pa act cnt
      vt.push_back(mk(0, 1, 0, 10, 0, 0, 0, 0,   0, 0, 0,  0, 1, 0));
      vt.push_back(mk(0, 1, 1, 20, 0, 0, 0, 0,   0, 0, 0,  0, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,  0, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1,   0, 0, 10, 0, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 10, 0, 3, 1));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 10, 0, 3, 2));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 10, 0, 3, 3));
      vt.push_back(mk(1, 0, 0, 0,  13, 0, 0, 0,  1, 0, 10, 0, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 10, 0, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1,   0, 0, 20, 1, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 20, 1, 3, 1));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 20, 1, 3, 2));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 20, 1, 3, 3));
      vt.push_back(mk(1, 0, 0, 0,  21, 0, 0, 0,  1, 0, 20, 1, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1,   0, 0, 13, 0, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 13, 0, 3, 1));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 13, 0, 3, 2));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 13, 0, 3, 3));
      vt.push_back(mk(1, 0, 0, 0,  17, 0, 0, 0,  1, 0, 13, 0, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1,   0, 0, 21, 1, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  25, 1, 0, 0,  0, 1, 21, 1, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 21, 1, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1,   0, 0, 17, 0, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 17, 0, 3, 1));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 17, 0, 3, 2));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 17, 0, 3, 3));
      vt.push_back(mk(1, 0, 0, 0,  19, 0, 0, 0,  1, 0, 17, 0, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1,   0, 0, 26, 1, 3, 0));
      vt.push_back(mk(1, 0, 0, 0,  30, 1, 1, 0,  1, 0, 26, 1, 1, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1,   0, 0, 19, 0, 1, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 1, 0,   1, 0, 19, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1,   0, 0, 19, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 19, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1,   0, 0, 19, 0, 0, 0));

      foreach (vt[i]) begin
         habilita = vt[i].hab[0]; carrega_processo = vt[i].ld[0];
         slot_carga = vt[i].slot[1:0]; pc_carga = 32'(vt[i].pcl); pc = 32'(vt[i].pcv);
         instrucao_io = vt[i].io[0]; fim_processo = vt[i].fim[0]; despacho = vt[i].dsp[0];
         tick();
         chk_all($sformatf("vec%0d", i), vt[i].tc, vt[i].ioc, vt[i].pct, vt[i].pa,
                 vt[i].act, vt[i].cnt);
      end
      limpa();

      // Asynchronous reset in the middle of a quantum.
      carrega_processo = 1'b1; slot_carga = 2'd2; pc_carga = 32'h100;
      tick(); limpa();
      tick();
      despacho = 1'b1; tick(); despacho = 1'b0;
      chk_all("ar_disp", 0, 0, 32'h100, 2, 4'b0100, 0);
      tick(); tick();
      chk("ar_cont2", 32'(contador), 32'd2);
      #2 reset = 1'b0;
      #1 chk_all("ar_async", 0, 0, 0, 0, 0, 0);
      #2 reset = 1'b1;

      // habilita dropped while running; context survives.
      habilita = 1'b1;
      carrega_processo = 1'b1; slot_carga = 2'd3; pc_carga = 32'h40;
      tick(); limpa();
      tick();
      despacho = 1'b1; tick(); despacho = 1'b0;
      chk_all("hb_disp", 0, 0, 32'h40, 3, 4'b1000, 0);
      tick();
      despacho = 1'b1; tick(); despacho = 1'b0;
      chk("hb_ign_disp_cont", 32'(contador), 32'd2);
      habilita = 1'b0; tick();
      chk_all("hb_drop", 0, 0, 32'h40, 3, 4'b1000, 0);
      tick();
      chk("hb_idle_cont", 32'(contador), 32'd0);
      habilita = 1'b1; tick();
      chk_all("hb_raise", 0, 0, 32'h40, 3, 4'b1000, 0);
      despacho = 1'b1; tick(); despacho = 1'b0;
      chk_all("hb_restore", 0, 0, 32'h40, 3, 4'b1000, 0);
      pc = 32'hFFFF_FFFF; instrucao_io = 1'b1; tick(); limpa();
      chk("io_wrap_pulse", 32'(intrucao_io_contexto), 32'd1);
      despacho = 1'b1; tick(); despacho = 1'b0;
      chk_all("io_wrap_restore", 0, 0, 0, 3, 4'b1000, 0);

      // Random traffic against the reference model.
      habilita = 1'b0;
      reset = 1'b0; #4 reset = 1'b1;
      model_reset();
      for (int c = 0; c < 2000; c++) begin
         habilita         = ($urandom_range(0, 19) != 0);
         carrega_processo = ($urandom_range(0, 7) == 0);
         slot_carga       = 2'($urandom_range(0, 3));
         pc_carga         = $urandom;
         pc               = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
         instrucao_io     = ($urandom_range(0, 9) == 0);
         fim_processo     = ($urandom_range(0, 11) == 0);
         despacho         = ($urandom_range(0, 3) == 0);
         model_edge();
         tick();
         chk_all($sformatf("rnd%0d", c), int'(m_tc), int'(m_ioc), int'(m_pct), m_pa(),
                 m_act(), m_cnt);
      end
      limpa();

      $display("%0d/%0d checks passed", passou, total);
      $finish;
   end

endmodule
